// File: rtl/cordic_z_seq.sv
// cordic_z_seq: iteration sequencer for the CORDIC Z-path arctangent ROM.
//   clk_i/rst_i         : clock, synchronous active-high reset
//   beg_i, iter_last_i  : start request and final iteration index (latched on accept)
//   ack_i               : acknowledges done_o
//   rdy_o, load_o       : idle indicator, one-cycle operand load strobe
//   en_rom1_o, adrs_o   : ROM read enable and address
//   iter_en_o, iter_idx_o : datapath update strobe and current iteration index
//   done_o              : result valid, held until ack_i
//   Define CORDIC_Z_PREFETCH_EN to overlap ROM fetch with execute (1 cycle/iteration).
module cordic_z_seq #(
  parameter int ITER_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              beg_i,
  input  logic [ITER_W-1:0] iter_last_i,
  input  logic              ack_i,
  output logic              rdy_o,
  output logic              load_o,
  output logic              en_rom1_o,
  output logic [ITER_W-1:0] adrs_o,
  output logic              iter_en_o,
  output logic [ITER_W-1:0] iter_idx_o,
  output logic              done_o
);
`ifdef CORDIC_Z_PREFETCH_EN
  localparam logic PREFETCH = 1'b1;
`else
  localparam logic PREFETCH = 1'b0;
`endif
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d, last_q, last_d, adrs_d, idx_d;
  logic              pf_d, en_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: if (beg_i) begin
        state_d = S_LOAD;
        last_d  = iter_last_i;
        cnt_d   = '0;
      end
      S_LOAD:  state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      // terminal compare precedes the increment, so the counter never wraps
      S_EXEC: if (cnt_q == last_q) state_d = S_DONE;
      else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = PREFETCH ? S_EXEC : S_FETCH;
      end
      S_DONE:  state_d = ack_i ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs are decoded from next-state values so they leave this block registered
  always_comb begin
    pf_d   = PREFETCH && state_d == S_EXEC && cnt_d != last_d;
    en_d   = state_d == S_FETCH || pf_d;
    adrs_d = state_d == S_FETCH ? cnt_d : pf_d ? cnt_d + 1'b1 : adrs_o;
    idx_d  = state_d == S_EXEC ? cnt_d : iter_idx_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      rdy_o      <= 1'b1;
      load_o     <= 1'b0;
      en_rom1_o  <= 1'b0;
      adrs_o     <= '0;
      iter_en_o  <= 1'b0;
      iter_idx_o <= '0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rdy_o      <= state_d == S_IDLE;
      load_o     <= state_d == S_LOAD;
      en_rom1_o  <= en_d;
      adrs_o     <= adrs_d;
      iter_en_o  <= state_d == S_EXEC;
      iter_idx_o <= idx_d;
      done_o     <= state_d == S_DONE;
    end
  end
endmodule

// File: doc/cordic_z_seq.md
# cordic_z_seq

Iteration sequencer for the CORDIC Z-path arctangent ROM (32 × 32-bit IEEE-754 single-precision constants, synchronous read, 1-cycle latency, read enable + 5-bit address). On a start request it loads the X/Y/Z operand registers and steps the ROM address from 0 to a run-time last index. It strobes the datapath once per iteration, aligned with valid ROM data, then reports completion through a held DONE/ACK handshake.

## Interface
- ITER_W, default 5: iteration index / ROM address width. The ROM depth is 2^ITER_W.

Ports:
- CLK, in, 1: system clock. All state changes on the rising edge.
- RST, in, 1: synchronous, active-high reset.
- BEG, in, 1: start request. Sampled only while RDY=1.
- ITER_LAST, in, ITER_W: index of the final iteration, so N = ITER_LAST+1 iterations. Latched when BEG is accepted.
- ACK, in, 1: acknowledges DONE. Sampled only while DONE=1.
- RDY, out, 1: high in IDLE.
- LOAD, out, 1: one-cycle strobe that loads the initial X/Y/Z operands.
- EN_ROM1, out, 1: ROM read enable.
- ADRS, out, ITER_W: ROM address. Registered.
- ITER_EN, out, 1: datapath update strobe. ROM data for ITER_IDX is valid in this cycle.
- ITER_IDX, out, ITER_W: index of the iteration currently executing. Gives the datapath its shift amount.
- DONE, out, 1: result valid. Held until ACK.

## Operation
- States: IDLE, LOAD, FETCH, EXEC, DONE.
- **IDLE**: RDY=1.
  - BEG=1 → LOAD. The block latches ITER_LAST into last_r and clears the counter.
  - BEG=0 → stay in IDLE.
- **LOAD**: LOAD=1 → FETCH.
- **FETCH**: EN_ROM1=1, ADRS=cnt → EXEC.
- **EXEC**: ITER_EN=1, ITER_IDX=cnt.
  - cnt==last_r → DONE.
  - Otherwise cnt+1 → FETCH.
- **DONE**: DONE=1.
  - ACK=1 → IDLE.
  - ACK=0 → hold DONE.
- EN_ROM1 is low outside fetch cycles, so the ROM output holds its last value.
- The counter is ITER_W bits wide. It never wraps: the terminal compare happens before the increment, so ITER_LAST = 2^ITER_W−1 runs all 32 iterations and exits cleanly.
- ITER_LAST=0 runs exactly one iteration.
- BEG is ignored in every state except IDLE. No request is queued.
- Changes on ITER_LAST after acceptance have no effect on the current run.
- BEG and ACK high together in DONE: the block goes to IDLE only. BEG is not accepted until RDY=1.
- RST in any state: the next edge forces IDLE with all outputs at their reset values. The current run is discarded and DONE is not asserted.

## Timing
- Reset values: RDY=1, LOAD=0, EN_ROM1=0, ADRS=0, ITER_EN=0, ITER_IDX=0, DONE=0.
- BEG is accepted at edge k.
- LOAD is high during cycle k+1.
- Baseline schedule, for iteration i:
  - FETCH (EN_ROM1=1, ADRS=i) in cycle k+2+2i.
  - EXEC (ITER_EN=1, ITER_IDX=i) in cycle k+3+2i.
  - DONE rises in cycle k+2+2N.
  - Throughput: 2 cycles per iteration.
- DONE falls in the cycle after the edge at which ACK=1 is sampled. RDY rises in that same cycle.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- Macro: CORDIC_Z_PREFETCH_EN.
- Defined: fetch overlaps execute.
  - After the first FETCH (cycle k+2), each EXEC cycle for i<last_r also drives EN_ROM1=1, ADRS=i+1.
  - EXEC i occurs in cycle k+3+i, and EXEC repeats directly without returning to FETCH.
  - In the last EXEC, EN_ROM1=0.
  - DONE rises in cycle k+3+N.
  - Throughput: 1 cycle per iteration.
- Undefined: baseline 2-cycle FETCH/EXEC schedule.
- Handshake, reset behaviour and boundary rules are identical in both builds.

## Test plan
- Reset, then idle 5 cycles: RDY=1 and all other outputs 0. BEG pulse with ITER_LAST=0: LOAD at k+1, FETCH ADRS=0 at k+2, ITER_EN at k+3, DONE at k+4 (k+4 with prefetch). DONE holds 10 cycles until ACK, then RDY=1 the cycle after ACK.
- ITER_LAST=31: ADRS/ITER_IDX sequence 0..31 with no wrap and exactly 32 ITER_EN pulses.
  - Baseline: DONE at k+66.
  - Prefetch: DONE at k+35.
  - A scoreboard checks that ROM O_D equals the entry for ITER_IDX in every ITER_EN cycle.
- ITER_LAST=13, and ITER_LAST changed to 3 and BEG re-pulsed during EXEC: 14 iterations still run, and no second LOAD occurs before RDY returns.
- ACK and BEG high together in DONE: the block goes to IDLE. BEG is not accepted in that cycle (no LOAD in the next cycle). A BEG the following cycle starts a new run.
- RST asserted at iteration 7 of a 20-iteration run: the next cycle shows all outputs at reset values and DONE is never asserted. A new BEG restarts from ADRS=0.
- Both builds: back-to-back runs with ITER_LAST=4, ACK tied high, BEG tied high: each run produces exactly 5 ITER_EN pulses, and each run's first LOAD follows RDY by exactly 1 cycle.
